// File: rtl/pea_result_drain_if.sv
// pea_result_drain_if
//   Downstream valid/ready stream that carries one captured result/status pair and
//   its sequence tag.
//   Signals:
//     valid   pair is held on result/status/seq (driven by the drain)
//     ready   consumer accepts the pair when valid && ready
//     result  captured result word
//     status  captured status word
//     seq     sequence tag of the presented pair
//   Modports: master = drain side, slave = consumer side.
interface pea_result_drain_if #(
  parameter int WIDTH = 32,
  parameter int SEQ_W = 8
);
  logic             valid;
  logic             ready;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] status;
  logic [SEQ_W-1:0] seq;

  modport master (output valid, result, status, seq, input ready);
  modport slave  (input valid, result, status, seq, output ready);
endinterface

// File: rtl/pea_result_drain.sv
// pea_result_drain
//   Consumer end of the PEA output path. Pops one entry from the result FIFO and one
//   from the status FIFO together, registers the pair and presents it downstream with a
//   sequence tag. Also keeps a saturating count of pairs with non-zero status, and a
//   sticky desync flag for when one FIFO holds data too long while the other is empty.
//   Ports:
//     clk           system clock, rising edge
//     rst           asynchronous reset, active low
//     drain_en      allows a new pop to start; a pair already in flight always completes
//     result_pop    result FIFO population
//     status_pop    status FIFO population
//     result_data   result FIFO read data, valid one cycle after rd_en_result
//     status_data   status FIFO read data, valid one cycle after rd_en_status
//     rd_en_result  result FIFO read strobe, one-cycle pulse
//     rd_en_status  status FIFO read strobe, always pulsed with rd_en_result
//     out_if        downstream stream (valid/ready/result/status/seq)
//     err_count     saturating count of accepted pairs with non-zero status
//     desync        sticky FIFO skew flag, cleared only by reset
//     busy          high whenever the FSM is not idle
//
// state   | meaning
// IDLE    | waiting for both FIFOs to be non-empty with drain_en high
// READ    | both read strobes asserted for this one cycle
// WAIT    | FIFO read data valid; captured into the output registers at the next edge
// PRESENT | pair held on out_if until the consumer accepts it
module pea_result_drain #(
  parameter int WIDTH   = 32,
  parameter int POP_W   = 1,
  parameter int SEQ_W   = 8,
  parameter int TIMEOUT = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  drain_en,
  input  logic [POP_W-1:0]      result_pop,
  input  logic [POP_W-1:0]      status_pop,
  input  logic [WIDTH-1:0]      result_data,
  input  logic [WIDTH-1:0]      status_data,
  output logic                  rd_en_result,
  output logic                  rd_en_status,
  pea_result_drain_if.master    out_if,
  output logic [15:0]           err_count,
  output logic                  desync,
  output logic                  busy
);

  typedef enum logic [1:0] {IDLE, READ, WAIT, PRESENT} state_t;

  localparam int SKEW_W = $clog2(TIMEOUT + 1);

  state_t            state, state_nxt;
  logic              res_nz, sts_nz;
  logic              accept;
  logic [SKEW_W-1:0] skew_cnt;

  assign res_nz = |result_pop;
  assign sts_nz = |status_pop;
  assign accept = (state == PRESENT) && out_if.valid && out_if.ready;
  assign busy   = (state != IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    rd_en_result = 1'b0;
    rd_en_status = 1'b0;
    case (state)
      IDLE:    if (drain_en && res_nz && sts_nz) state_nxt = READ;
      READ: begin
        rd_en_result = 1'b1;
        rd_en_status = 1'b1;
        state_nxt    = WAIT;
      end
      WAIT:    state_nxt = PRESENT;
      PRESENT: if (accept) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_if.valid  <= 1'b0;
      out_if.result <= '0;
      out_if.status <= '0;
      out_if.seq    <= '0;
      err_count     <= '0;
    end else begin
      if (state == WAIT) begin
        out_if.result <= result_data;
        out_if.status <= status_data;
        out_if.valid  <= 1'b1;
      end
      if (accept) begin
        out_if.valid <= 1'b0;
        out_if.seq   <= out_if.seq + 1'b1;
        if ((out_if.status != '0) && (err_count != 16'hFFFF))
          err_count <= err_count + 16'd1;
      end
    end
  end

  // Skew counter saturates at TIMEOUT so a long skew cannot wrap it back below the
  // threshold; desync is raised on the edge where the count reaches TIMEOUT.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      skew_cnt <= '0;
      desync   <= 1'b0;
    end else if ((state == IDLE) && (res_nz != sts_nz)) begin
      if (skew_cnt != SKEW_W'(TIMEOUT))   skew_cnt <= skew_cnt + 1'b1;
      if (skew_cnt >= SKEW_W'(TIMEOUT - 1)) desync <= 1'b1;
    end else begin
      skew_cnt <= '0;
    end
  end

endmodule

// File: tb/tb_pea_result_drain.sv
// tb_pea_result_drain
//   Directed bench for pea_result_drain. A queue-based FIFO model feeds the drain, a
//   scoreboard holds the expected pairs in push order, and every accepted pair is popped
//   and compared against it together with the modelled sequence tag and error count.
module tb_pea_result_drain;
  localparam int WIDTH   = 32;
  localparam int POP_W   = 1;
  localparam int SEQ_W   = 8;
  localparam int TIMEOUT = 64;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               drain_en = 1'b0;
  logic [POP_W-1:0]   result_pop = '0;
  logic [POP_W-1:0]   status_pop = '0;
  logic [WIDTH-1:0]   result_data = '0;
  logic [WIDTH-1:0]   status_data = '0;
  logic               rd_en_result, rd_en_status;
  logic [15:0]        err_count;
  logic               desync, busy;

  pea_result_drain_if #(.WIDTH(WIDTH), .SEQ_W(SEQ_W)) out_if ();

  pea_result_drain #(
    .WIDTH(WIDTH), .POP_W(POP_W), .SEQ_W(SEQ_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .drain_en     (drain_en),
    .result_pop   (result_pop),
    .status_pop   (status_pop),
    .result_data  (result_data),
    .status_data  (status_data),
    .rd_en_result (rd_en_result),
    .rd_en_status (rd_en_status),
    .out_if       (out_if),
    .err_count    (err_count),
    .desync       (desync),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int rd_pulses = 0;
  int accepts = 0;
  logic [WIDTH-1:0]   res_q[$];
  logic [WIDTH-1:0]   sts_q[$];
  logic [2*WIDTH-1:0] sb_q[$];
  logic [SEQ_W-1:0]   exp_seq = '0;
  logic [15:0]        exp_err = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic update_pops();
    result_pop = (res_q.size() != 0) ? POP_W'(1) : '0;
    status_pop = (sts_q.size() != 0) ? POP_W'(1) : '0;
  endtask

  task automatic push_pair(input logic [WIDTH-1:0] r, input logic [WIDTH-1:0] s);
    res_q.push_back(r);
    sts_q.push_back(s);
    sb_q.push_back({r, s});
    update_pops();
  endtask

  // One clock: monitor at the falling edge, then model the FIFO reads after the rising edge.
  task automatic step();
    logic rr, rs;
    logic [2*WIDTH-1:0] e;
    @(negedge clk);
    rr = rd_en_result;
    rs = rd_en_status;
    if (rst) begin
      chk("strobes_together", rs, rr);
      chk("err_count", err_count, exp_err);
      if (rr) begin
        rd_pulses++;
        chk("pop_only_nonempty", (res_q.size() != 0 && sts_q.size() != 0), 1);
      end
      if (out_if.valid && out_if.ready) begin
        accepts++;
        chk("sb_has_entry", (sb_q.size() != 0), 1);
        if (sb_q.size() != 0) begin
          e = sb_q.pop_front();
          chk("out_result", out_if.result, e[2*WIDTH-1:WIDTH]);
          chk("out_status", out_if.status, e[WIDTH-1:0]);
          chk("out_seq", out_if.seq, exp_seq);
          exp_seq++;
          if (e[WIDTH-1:0] != '0 && exp_err != 16'hFFFF) exp_err++;
        end
      end
    end
    @(posedge clk);
    #1;
    if (rr && res_q.size() != 0) result_data = res_q.pop_front();
    if (rs && sts_q.size() != 0) status_data = sts_q.pop_front();
    update_pops();
  endtask

  task automatic wait_accept(input int n, input int budget);
    int target;
    target = accepts + n;
    for (int i = 0; i < budget && accepts < target; i++) step();
    chk("accept_count", accepts, target);
  endtask

  task automatic wait_valid(input int budget, output int cyc);
    cyc = 0;
    while (!out_if.valid && cyc < budget) begin
      step();
      cyc++;
    end
    chk("valid_seen", out_if.valid, 1'b1);
  endtask

  task automatic model_reset();
    res_q.delete();
    sts_q.delete();
    sb_q.delete();
    exp_seq = '0;
    exp_err = '0;
    update_pops();
  endtask

  initial begin
    int cyc;
    out_if.ready = 1'b1;

    // Reset state
    #2;
    chk("rst_rd_en_result", rd_en_result, 0);
    chk("rst_rd_en_status", rd_en_status, 0);
    chk("rst_valid", out_if.valid, 0);
    chk("rst_result", out_if.result, 0);
    chk("rst_status", out_if.status, 0);
    chk("rst_seq", out_if.seq, 0);
    chk("rst_err", err_count, 0);
    chk("rst_desync", desync, 0);
    chk("rst_busy", busy, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    step();
    chk("post_rst_busy", busy, 0);

    // Reset asserted while a pair sits in WAIT: the pair is discarded
    drain_en = 1'b1;
    push_pair(32'hDEAD_0001, 32'h0000_0003);
    step();
    step();
    rst = 1'b0;
    #1;
    chk("rst_wait_valid", out_if.valid, 0);
    chk("rst_wait_busy", busy, 0);
    model_reset();
    step();
    step();
    rst = 1'b1;
    repeat (3) step();
    chk("rst_wait_idle_busy", busy, 0);
    chk("rst_wait_idle_valid", out_if.valid, 0);
    chk("rst_wait_seq", out_if.seq, 0);

    // Single pair: latency and content
    rd_pulses = 0;
    push_pair(32'h0000_0019, 32'h0);
    wait_valid(20, cyc);
    chk("latency", cyc, 3);
    chk("single_rd_pulses", rd_pulses, 1);
    chk("single_result", out_if.result, 32'h19);
    chk("single_status", out_if.status, 32'h0);
    chk("single_seq", out_if.seq, 0);
    wait_accept(1, 10);
    chk("single_valid_drop", out_if.valid, 0);
    chk("single_err", err_count, 0);

    // Backpressure: outputs stable, no second pop while held
    out_if.ready = 1'b0;
    push_pair(32'hA5A5_0001, 32'h0);
    push_pair(32'hA5A5_0002, 32'h0);
    wait_valid(20, cyc);
    rd_pulses = 0;
    repeat (10) begin
      step();
      chk("bp_valid", out_if.valid, 1);
      chk("bp_result", out_if.result, 32'hA5A5_0001);
      chk("bp_seq", out_if.seq, 1);
    end
    chk("bp_no_pop", rd_pulses, 0);
    out_if.ready = 1'b1;
    wait_accept(1, 10);
    chk("bp_seq_after", out_if.seq, 2);
    wait_accept(1, 20);

    // Error counting and saturation
    push_pair(32'h100, 32'h2);
    push_pair(32'h101, 32'h0);
    push_pair(32'h102, 32'h5);
    wait_accept(3, 40);
    step();
    chk("err_two", err_count, 16'd2);
    force dut.err_count = 16'hFFFF;
    exp_err = 16'hFFFF;
    step();
    release dut.err_count;
    step();
    chk("err_forced", err_count, 16'hFFFF);
    push_pair(32'h103, 32'h1);
    wait_accept(1, 20);
    step();
    chk("err_saturate", err_count, 16'hFFFF);

    // Desync: result present, status empty for TIMEOUT cycles
    repeat (2) step();
    rd_pulses = 0;
    res_q.push_back(32'h55);
    update_pops();
    repeat (TIMEOUT - 1) step();
    chk("desync_before", desync, 0);
    step();
    chk("desync_set", desync, 1);
    chk("desync_no_pop", rd_pulses, 0);
    sts_q.push_back(32'h7);
    sb_q.push_back({32'h55, 32'h7});
    update_pops();
    wait_accept(1, 20);
    chk("desync_sticky", desync, 1);

    // drain_en low holds off pops; enabling pops on the next cycle
    drain_en = 1'b0;
    push_pair(32'hBEEF, 32'h0);
    rd_pulses = 0;
    repeat (20) step();
    chk("hold_no_pop", rd_pulses, 0);
    chk("hold_busy", busy, 0);
    drain_en = 1'b1;
    step();
    chk("enable_pop", rd_en_result, 1);
    wait_accept(1, 20);

    // 256 pairs: sequence tag wraps through 255 -> 0
    for (int i = 0; i < 256; i++)
      push_pair($urandom(), ((i % 3) == 0) ? 32'h0 : WIDTH'($urandom_range(1, 9)));
    wait_accept(256, 256 * 4 + 50);
    step();
    chk("seq_final", out_if.seq, exp_seq);
    chk("final_desync", desync, 1);
    chk("final_busy", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
